wall_control: RTL
=================

# wall_control

Sequencing controller for the wall datapath in the flappy-style game. Once per frame tick it erases the wall at its current position, issues a single-cycle update command to the wall datapath (which moves the wall and loads a new hole position), waits one cycle for the datapath outputs to settle, then redraws the wall with its hole. It drives the datapath's 2-bit state input and the VGA plotter's pixel interface. It also owns frame pacing and frame-tick buffering for the wall.

## Interface
Parameters:
- SCREEN_W, 160, visible width in pixels; pixels with x ≥ SCREEN_W are never plotted
- SCREEN_H, 120, wall height in rows (rows 0..SCREEN_H-1)
- WALL_W, 4, wall width in columns
- HOLE_H, 32, hole height in rows

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  game running; frames start only while high
- frame_tick  in  1  one-cycle pulse per video frame
- wall_x  in  8  wall left edge, from wall datapath
- hole_y  in  8  hole top row, from wall datapath
- cur_state  out  2  command to wall datapath: 0=UPDATE, 1=ERASE, 2=DRAW, 3=IDLE
- plot  out  1  pixel write strobe to VGA plotter
- x_out  out  8  pixel x
- y_out  out  8  pixel y
- colour  out  3  pixel colour
- busy  out  1  high whenever the FSM is not in IDLE
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- FSM states:
  - IDLE: cur_state=3, plot=0.
    - Go to ERASE when enable && (frame_tick || pending).
    - On that transition: latch x_base←wall_x, clear pending, reset the counters.
  - ERASE: cur_state=1.
    - Scan all WALL_W×SCREEN_H pixels, one per cycle, colour=3'b000.
    - After the last pixel, go to UPDATE.
  - UPDATE: cur_state=0 for exactly one cycle, plot=0. Then go to SETTLE.
  - SETTLE: cur_state=3, plot=0.
    - Latch x_base←wall_x and hole_base←hole_y.
    - Reset the counters, then go to DRAW.
  - DRAW: cur_state=2.
    - Scan the same pixel order as ERASE.
    - colour=3'b000 when hole_base ≤ y < hole_base+HOLE_H, else 3'b010 (green).
    - After the last pixel, go to DONE.
  - DONE: frame_done=1, cur_state=3, plot=0. Then go to IDLE.
- Scan order:
  - col counter (0..WALL_W-1) is the inner loop; row counter (0..SCREEN_H-1) is the outer loop.
  - x_out = x_base + col, y_out = row.
- Off-screen columns:
  - x_base+col is computed at 9 bits.
  - If the sum is ≥ SCREEN_W, plot=0 for that pixel, but the scan still advances (no skipping, fixed duration).
  - x_out carries the low 8 bits of the sum.
- Hole compare is done at 9 bits, so hole_base+HOLE_H > 255 does not wrap. Rows below the hole are green up to SCREEN_H-1.
- Tick buffering:
  - A frame_tick arriving in any non-IDLE state sets pending.
  - Any number of such ticks collapse into one pending frame.
  - A frame_tick coincident with the IDLE→ERASE transition is consumed, not buffered.
- enable:
  - Deasserting enable mid-frame does not abort; the frame completes.
  - pending is retained while enable is low.
- reset:
  - Forces IDLE at any state, including mid-scan.
  - Clears pending, x_base, hole_base and the counters.

## Timing
- Reset values: cur_state=3, plot=0, x_out=0, y_out=0, colour=0, busy=0, frame_done=0.
- All outputs are functions of registered state and counters only; there is no combinational path from inputs to outputs.
- Cycle schedule, with tick sampled in IDLE at cycle T and N = WALL_W×SCREEN_H (480 by default):
  - ERASE: T+1..T+N.
  - UPDATE: T+N+1.
  - SETTLE: T+N+2.
  - DRAW: T+N+3..T+2N+2.
  - DONE: T+2N+3.
  - IDLE: T+2N+4.
  - Total with defaults: 964 cycles, busy high throughout.
- One pixel per cycle. The plotter samples x_out, y_out, colour and plot on the same clk edge; there is no backpressure.
- The datapath sees cur_state=0 for exactly one cycle per frame. Its outputs are sampled one cycle later (SETTLE).

## Test plan
- Reset, then idle with enable=0 and a tick:
  - Stimulus: reset; hold enable=0; pulse frame_tick.
  - Required: all outputs at reset values; cur_state stays 3; no plot; busy=0.
- Full frame:
  - Stimulus: enable=1, wall_x=100; single tick at T; datapath model returns wall_x=96, hole_y=40 after UPDATE.
  - Erase phase: 480 erase plots at x 100..103, colour 0.
  - Update phase: cur_state=0 only at T+481.
  - Draw phase: 480 draw plots at x 96..99; rows 40..71 colour 0, all other rows colour 2.
  - End: frame_done at T+963.
- Right-edge clipping:
  - Stimulus: wall_x=158, one frame.
  - Required: plot=1 only for x=158,159; plot=0 for the col 2,3 pixels; duration still 964 cycles.
- Hole near bottom:
  - Stimulus: hole_y=100.
  - Required: rows 100..119 colour 0, rows 0..99 colour 2; no wrap artifacts at 9-bit sum 132.
- Tick buffering:
  - Stimulus: three ticks during one frame.
  - Required: exactly one extra frame starts, with its first ERASE cycle at the cycle after IDLE is re-entered; then the FSM stays idle.
- Reset mid-DRAW:
  - Stimulus: assert reset at row 50 of DRAW, with pending set.
  - Required: next cycle is IDLE with plot=0 and cur_state=3; no frame_done; no frame starts without a new tick.

Source files
------------

// File: rtl/wall_control.sv
// wall_control: per-frame erase / update / settle / redraw sequencer for the wall datapath.
// Also paces frames and buffers frame ticks that arrive while a frame is in progress.
module wall_control #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int WALL_W   = 4,
    parameter int HOLE_H   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [7:0] wall_x,
    input  logic [7:0] hole_y,
    output logic [1:0] cur_state,
    output logic       plot,
    output logic [7:0] x_out,
    output logic [7:0] y_out,
    output logic [2:0] colour,
    output logic       busy,
    output logic       frame_done
);
    typedef enum logic [2:0] {IDLE, ERASE, UPDATE, SETTLE, DRAW, DONE} state_t;
    localparam logic [7:0] COL_LAST = 8'(WALL_W - 1);
    localparam logic [7:0] ROW_LAST = 8'(SCREEN_H - 1);
    localparam logic [8:0] SCR_W9   = 9'(SCREEN_W);
    localparam logic [8:0] HOLE_H9  = 9'(HOLE_H);
    state_t     state_q, state_d;
    logic       pending_q, pending_d;
    logic [7:0] x_base_q, x_base_d, hole_base_q, hole_base_d;
    logic [7:0] col_q, col_d, row_q, row_d;
    logic       last, col_wrap;
    logic [7:0] col_nxt, row_nxt;
    logic [8:0] x_sum, y9, hole_lo, hole_hi;
    logic       in_hole, scanning;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            x_base_q    <= 8'd0;
            hole_base_q <= 8'd0;
            col_q       <= 8'd0;
            row_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            x_base_q    <= x_base_d;
            hole_base_q <= hole_base_d;
            col_q       <= col_d;
            row_q       <= row_d;
        end
    end
    assign col_wrap = col_q == COL_LAST;
    assign last     = col_wrap && row_q == ROW_LAST;
    assign col_nxt  = col_wrap ? 8'd0 : col_q + 8'd1;
    assign row_nxt  = !col_wrap ? row_q : (last ? 8'd0 : row_q + 8'd1);
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | (frame_tick && state_q != IDLE);
        x_base_d    = x_base_q;
        hole_base_d = hole_base_q;
        col_d       = col_q;
        row_d       = row_q;
        case (state_q)
            IDLE: if (enable && (frame_tick || pending_q)) begin
                state_d   = ERASE;
                x_base_d  = wall_x;
                pending_d = 1'b0;
                col_d     = 8'd0;
                row_d     = 8'd0;
            end
            ERASE: begin
                col_d   = col_nxt;
                row_d   = row_nxt;
                state_d = last ? UPDATE : ERASE;
            end
            UPDATE: state_d = SETTLE;
            // datapath outputs have settled one cycle after the update command
            SETTLE: begin
                x_base_d    = wall_x;
                hole_base_d = hole_y;
                col_d       = 8'd0;
                row_d       = 8'd0;
                state_d     = DRAW;
            end
            DRAW: begin
                col_d   = col_nxt;
                row_d   = row_nxt;
                state_d = last ? DONE : DRAW;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // 9-bit sums so off-screen columns and a hole reaching past 255 never wrap
    assign x_sum    = {1'b0, x_base_q} + {1'b0, col_q};
    assign y9       = {1'b0, row_q};
    assign hole_lo  = {1'b0, hole_base_q};
    assign hole_hi  = hole_lo + HOLE_H9;
    assign in_hole  = y9 >= hole_lo && y9 < hole_hi;
    assign scanning = state_q == ERASE || state_q == DRAW;
    assign cur_state  = state_q == UPDATE ? 2'd0 : state_q == ERASE ? 2'd1 :
                        state_q == DRAW ? 2'd2 : 2'd3;
    assign plot       = scanning && x_sum < SCR_W9;
    assign x_out      = x_sum[7:0];
    assign y_out      = row_q;
    assign colour     = (state_q == DRAW && !in_hole) ? 3'b010 : 3'b000;
    assign busy       = state_q != IDLE;
    assign frame_done = state_q == DONE;
endmodule
